button_event_ctrl: RTL



---
 rtl/btn_evt_pkg.sv | 26 ++
 rtl/button_event_ctrl_ms_timer.sv | 39 +++
 rtl/button_event_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and timing helpers for the button gesture sequencer.
package btn_evt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        HOLD,
        GAP,
        PRESS2
    } state_t;

    // Number of clk cycles in a span of whole milliseconds.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_ctrl_ms_timer.sv
// Millisecond prescaler: tick_o is high for the last cycle of every ms.
module ms_timer
    import btn_evt_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_o
);

    localparam int unsigned CYC = ms_to_cycles(CLK_HZ, 1);
    localparam int unsigned PW  = (CYC > 1) ? $clog2(CYC) : 1;
    localparam logic [PW-1:0] LAST = PW'(CYC - 1);

    logic [PW-1:0] pre_cnt_q;
    logic [PW-1:0] pre_cnt_d;

    // Count 0..CYC-1, restarting on wrap or on an explicit clear.
    always_comb begin
        pre_cnt_d = pre_cnt_q + PW'(1);
        if (clr || (pre_cnt_q == LAST)) begin
            pre_cnt_d = '0;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

    assign tick_o = (pre_cnt_q == LAST);

endmodule

// File: rtl/button_event_ctrl.sv
// Button gesture classifier: short press, long press + auto-repeat, double click.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200,
    parameter int unsigned DCLICK_MS = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic btn,
    output logic short_press,
    output logic long_press,
    output logic repeat_evt,
    output logic double_click,
    output logic busy
);

    localparam int unsigned MS_MAX = max3(LONG_MS, REPEAT_MS, DCLICK_MS);
    localparam int unsigned MW     = $clog2(MS_MAX + 1);
    localparam logic [MW-1:0] LONG_LAST = MW'(LONG_MS - 1);
    localparam logic [MW-1:0] REP_LAST  = MW'(REPEAT_MS - 1);
    localparam logic [MW-1:0] GAP_LAST  = MW'(DCLICK_MS - 1);

    state_t        state_q;
    state_t        state_d;
    logic [MW-1:0] ms_cnt_q;
    logic [MW-1:0] ms_cnt_d;
    logic          tick;
    logic          clr;
    logic          long_hit;
    logic          rep_hit;
    logic          gap_hit;
    logic          short_d;
    logic          long_d;
    logic          rep_d;
    logic          dbl_d;

    ms_timer #(
        .CLK_HZ(CLK_HZ)
    ) u_ms_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .tick_o(tick)
    );

    assign long_hit = tick && (ms_cnt_q == LONG_LAST);
    assign rep_hit  = tick && (ms_cnt_q == REP_LAST);
    assign gap_hit  = tick && (ms_cnt_q == GAP_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; button edges are tested before timeouts so they win ties.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (btn) state_d = PRESS1;
            PRESS1:  if (!btn) state_d = GAP; else if (long_hit) state_d = HOLD;
            HOLD:    if (!btn) state_d = IDLE;
            GAP:     if (btn) state_d = PRESS2; else if (gap_hit) state_d = IDLE;
            PRESS2:  if (!btn) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d = IDLE;
        end
    end

    // Event decode, evaluated on the current state and the sampled inputs.
    always_comb begin
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        dbl_d   = 1'b0;
        if (en) begin
            case (state_q)
                PRESS1:  long_d = btn && long_hit;
                HOLD:    rep_d  = btn && rep_hit;
                GAP: begin
                    dbl_d   = btn;
                    short_d = !btn && gap_hit;
                end
                default: ;
            endcase
        end
    end

    // Timebase clears on any transition, on each repeat, and in untimed states.
    always_comb begin
        clr = (state_d != state_q) || rep_d ||
              !(state_q inside {PRESS1, HOLD, GAP});
        ms_cnt_d = ms_cnt_q;
        if (clr) begin
            ms_cnt_d = '0;
        end else if (tick) begin
            ms_cnt_d = ms_cnt_q + MW'(1);
        end
    end

    // Millisecond counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ms_cnt_q <= '0;
        end else begin
            ms_cnt_q <= ms_cnt_d;
        end
    end

    // Registered outputs, aligned with the state they accompany.
    always_ff @(posedge clk) begin
        if (rst) begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_evt   <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= short_d;
            long_press   <= long_d;
            repeat_evt   <= rep_d;
            double_click <= dbl_d;
            busy         <= (state_d != IDLE);
        end
    end

endmodule
